// File: rtl/ram32k_arbiter.sv
// Two-port byte/halfword/word sequencer in front of a byte-wide single-port RAM.
// Define RAM32K_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module ram32k_arbiter #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic [31:0]       a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic [31:0]       b_rdata,
  output logic              b_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout
);

  typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;

  state_t              state;
  logic                owner;    // 0 = port A, 1 = port B
  logic                we_q;
  logic [ADDR_W-1:0]   base;
  logic [31:0]         wdata_q;
  logic [1:0]          n_last;   // byte count minus one
  logic [1:0]          cnt;
  logic [31:0]         rbuf;

  logic                any_req;
  logic                grant_b;
  logic                sel_we;
  logic [1:0]          sel_size;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;
  logic [1:0]          sel_last;
  logic [1:0]          cnt_nx;
  logic [1:0]          cap_idx;
  logic [31:0]         rd_next;

  assign any_req = a_req | b_req;

`ifdef RAM32K_ARB_RR_EN
  logic last_b;
  // On a tie the port not granted last time wins; a lone requester always wins.
  assign grant_b = b_req & (~a_req | ~last_b);
`else
  assign grant_b = b_req & ~a_req;
`endif

  assign sel_we    = grant_b ? b_we    : a_we;
  assign sel_size  = grant_b ? b_size  : a_size;
  assign sel_addr  = grant_b ? b_addr  : a_addr;
  assign sel_wdata = grant_b ? b_wdata : a_wdata;

  always_comb begin
    sel_last = 2'd3;
    case (sel_size)
      2'b00:   sel_last = 2'd0;
      2'b01:   sel_last = 2'd1;
      default: sel_last = 2'd3;
    endcase
  end

  assign cnt_nx = cnt + 2'd1;

  // RAM read data lags the address by one cycle, so XFER step cnt captures byte cnt-1
  // and TAIL picks up the final byte.
  assign cap_idx = (state == TAIL) ? n_last : (cnt - 2'd1);

  always_comb begin
    rd_next = rbuf;
    rd_next[{cap_idx, 3'b000} +: 8] = ram_dout;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      owner    <= 1'b0;
      we_q     <= 1'b0;
      base     <= '0;
      wdata_q  <= '0;
      n_last   <= '0;
      cnt      <= '0;
      rbuf     <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
`ifdef RAM32K_ARB_RR_EN
      last_b   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= grant_b;
            we_q     <= sel_we;
            base     <= sel_addr;
            wdata_q  <= sel_wdata;
            n_last   <= sel_last;
            cnt      <= 2'd0;
            rbuf     <= '0;
            ram_addr <= sel_addr;
            ram_din  <= sel_wdata[7:0];
            ram_we   <= sel_we;
            state    <= XFER;
`ifdef RAM32K_ARB_RR_EN
            last_b   <= grant_b;
`endif
          end
        end
        XFER: begin
          if (!we_q && cnt != 2'd0) rbuf <= rd_next;
          cnt <= cnt_nx;
          if (cnt == n_last) begin
            ram_we  <= 1'b0;
            ram_din <= '0;
            if (we_q) begin
              a_ack <= ~owner;
              b_ack <= owner;
              state <= DONE;
            end else begin
              state <= TAIL;
            end
          end else begin
            ram_addr <= base + ADDR_W'(cnt_nx);
            ram_din  <= wdata_q[{cnt_nx, 3'b000} +: 8];
            ram_we   <= we_q;
          end
        end
        TAIL: begin
          rbuf <= rd_next;
          if (owner) b_rdata <= rd_next;
          else       a_rdata <= rd_next;
          a_ack <= ~owner;
          b_ack <= owner;
          state <= DONE;
        end
        DONE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram32k_arbiter.sv
// Scoreboard bench for ram32k_arbiter: a byte RAM model, expected acks queued at issue
// and checked by a monitor as acks appear, plus per-scenario latency and memory checks.
module tb_ram32k_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        a_req, a_we, b_req, b_we;
  logic [1:0]  a_size, b_size;
  logic [14:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic        a_ack, b_ack;
  logic [14:0] ram_addr;
  logic [7:0]  ram_din, ram_dout;
  logic        ram_we;

  logic [7:0]  mem [0:32767];

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  ram32k_arbiter #(.ADDR_W(15)) dut (
    .clk(clk), .resetn(resetn),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Byte RAM: synchronous write, registered read of the presented address.
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_din;
  end

  // Ack monitor: pop the scoreboard in issue order.
  always @(negedge clk) begin
    if (a_ack || b_ack) begin
      exp_t e;
      logic [31:0] rd;
      checks++;
      if (a_ack && b_ack) begin
        failures++;
        $display("FAIL dual_ack: a_ack=%0b b_ack=%0b, required at most one", a_ack, b_ack);
      end else if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b with nothing outstanding", a_ack, b_ack);
      end else begin
        e = expq.pop_front();
        if (b_ack !== e.port) begin
          failures++;
          $display("FAIL grant_order: ack on port %0s, required port %0s",
                   b_ack ? "B" : "A", e.port ? "B" : "A");
        end else if (!e.we) begin
          checks++;
          rd = e.port ? b_rdata : a_rdata;
          if (rd !== e.data) begin
            failures++;
            $display("FAIL rdata_%0s: got %08h, required %08h", e.port ? "B" : "A", rd, e.data);
          end
        end
      end
    end
  end

  task automatic set_port(input logic port, input logic req, input logic we,
                          input logic [1:0] size, input logic [14:0] addr, input logic [31:0] wd);
    if (port) begin
      b_req = req; b_we = we; b_size = size; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = req; a_we = we; a_size = size; a_addr = addr; a_wdata = wd;
    end
  endtask

  // Caller is just past a rising edge with the DUT in IDLE; that cycle is cycle 0.
  task automatic run_txn(input logic port, input logic we, input logic [1:0] size,
                         input logic [14:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input int exp_lat, input logic hold,
                         input string name);
    int cyc = 0;
    bit got = 0;
    expq.push_back('{port: port, we: we, data: exp_rd});
    set_port(port, 1'b1, we, size, addr, wd);
    while (cyc < 40 && !got) begin
      @(negedge clk);
      if (port ? b_ack : a_ack) got = 1;
      else cyc++;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout: no ack within 40 cycles, required at cycle %0d", name, exp_lat);
    end else if (cyc != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: ack at cycle %0d, required %0d", name, cyc, exp_lat);
    end
    @(posedge clk); #1;
    if (!hold) set_port(port, 1'b0, 1'b0, 2'b00, 15'h0, 32'h0);
  endtask

  task automatic check_mem(input logic [14:0] addr, input logic [7:0] exp, input string name);
    checks++;
    if (mem[addr] !== exp) begin
      failures++;
      $display("FAIL %s_mem[%04h]: got %02h, required %02h", name, addr, mem[addr], exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 2'b00, 15'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 2'b00, 15'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 15'h0 || ram_din !== 8'h0 || a_ack !== 1'b0 ||
        b_ack !== 1'b0 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: we=%0b addr=%04h din=%02h acks=%0b%0b ard=%08h brd=%08h, required all zero",
               ram_we, ram_addr, ram_din, a_ack, b_ack, a_rdata, b_rdata);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_word_wr_rd();
    run_txn(1'b0, 1'b1, 2'b10, 15'h0100, 32'hDEADBEEF, 32'h0, 5, 1'b0, "a_word_wr");
    check_mem(15'h0100, 8'hEF, "a_word_wr");
    check_mem(15'h0101, 8'hBE, "a_word_wr");
    check_mem(15'h0102, 8'hAD, "a_word_wr");
    check_mem(15'h0103, 8'hDE, "a_word_wr");
    run_txn(1'b0, 1'b0, 2'b10, 15'h0100, 32'h0, 32'hDEADBEEF, 6, 1'b0, "a_word_rd");
  endtask

  task automatic test_b_reads();
    run_txn(1'b1, 1'b0, 2'b00, 15'h0102, 32'hFFFFFFFF, 32'h000000AD, 3, 1'b0, "b_byte_rd");
    run_txn(1'b1, 1'b0, 2'b01, 15'h0101, 32'h0, 32'h0000ADBE, 4, 1'b0, "b_half_rd");
    checks++;
    if (a_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL a_rdata_hold: got %08h, required DEADBEEF", a_rdata);
    end
    // size 11 behaves as a word
    run_txn(1'b0, 1'b0, 2'b11, 15'h0100, 32'h0, 32'hDEADBEEF, 6, 1'b0, "a_size3_rd");
  endtask

  task automatic test_wrap();
    run_txn(1'b0, 1'b1, 2'b10, 15'h7FFE, 32'h11223344, 32'h0, 5, 1'b0, "wrap_wr");
    check_mem(15'h7FFE, 8'h44, "wrap");
    check_mem(15'h7FFF, 8'h33, "wrap");
    check_mem(15'h0000, 8'h22, "wrap");
    check_mem(15'h0001, 8'h11, "wrap");
    run_txn(1'b1, 1'b0, 2'b10, 15'h7FFE, 32'h0, 32'h11223344, 6, 1'b0, "wrap_rd");
  endtask

  task automatic test_simultaneous();
    int a_i = 0, b_i = 0, cyc = 0;
    logic ga, gb;
    exp_t ea0, ea1, eb0, eb1;
    do_reset();
    for (int i = 0; i < 8; i++) mem[15'h0200 + 15'(i)] = 8'(8'h10 + i);
    mem[15'h0300] = 8'h5A;
    mem[15'h0301] = 8'hC3;
    ea0 = '{port: 1'b0, we: 1'b0, data: 32'h13121110};
    ea1 = '{port: 1'b0, we: 1'b0, data: 32'h17161514};
    eb0 = '{port: 1'b1, we: 1'b0, data: 32'h0000005A};
    eb1 = '{port: 1'b1, we: 1'b0, data: 32'h000000C3};
`ifdef RAM32K_ARB_RR_EN
    expq.push_back(ea0); expq.push_back(eb0); expq.push_back(ea1); expq.push_back(eb1);
`else
    expq.push_back(ea0); expq.push_back(ea1); expq.push_back(eb0); expq.push_back(eb1);
`endif
    set_port(1'b0, 1'b1, 1'b0, 2'b10, 15'h0200, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 2'b00, 15'h0300, 32'h0);
    while ((a_i < 2 || b_i < 2) && cyc < 100) begin
      @(negedge clk);
      ga = a_ack; gb = b_ack;
      @(posedge clk); #1;
      cyc++;
      if (ga) begin
        a_i++;
        if (a_i < 2) set_port(1'b0, 1'b1, 1'b0, 2'b10, 15'h0204, 32'h0);
        else         set_port(1'b0, 1'b0, 1'b0, 2'b00, 15'h0, 32'h0);
      end
      if (gb) begin
        b_i++;
        if (b_i < 2) set_port(1'b1, 1'b1, 1'b0, 2'b00, 15'h0301, 32'h0);
        else         set_port(1'b1, 1'b0, 1'b0, 2'b00, 15'h0, 32'h0);
      end
    end
    checks++;
    if (a_i != 2 || b_i != 2) begin
      failures++;
      $display("FAIL simult_count: a acks=%0d b acks=%0d, required 2 and 2", a_i, b_i);
    end
  endtask

  task automatic test_reset_mid_write();
    for (int i = 0; i < 4; i++) mem[15'h0500 + 15'(i)] = 8'h00;
    set_port(1'b0, 1'b1, 1'b1, 2'b10, 15'h0500, 32'hA1B2C3D4);
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 2'b00, 15'h0, 32'h0);
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 15'h0 || ram_din !== 8'h0) begin
      failures++;
      $display("FAIL midreset_async: we=%0b addr=%04h din=%02h, required 0/0000/00",
               ram_we, ram_addr, ram_din);
    end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_mem(15'h0500, 8'hD4, "midreset");
    check_mem(15'h0501, 8'h00, "midreset");
    check_mem(15'h0502, 8'h00, "midreset");
    check_mem(15'h0503, 8'h00, "midreset");
    run_txn(1'b0, 1'b0, 2'b00, 15'h0500, 32'h0, 32'h000000D4, 3, 1'b0, "post_reset_rd");
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 1'b1, 2'b10, 15'h0400, 32'hCAFEF00D, 32'h0, 5, 1'b1, "b2b_wr");
    run_txn(1'b0, 1'b0, 2'b10, 15'h0400, 32'h0, 32'hCAFEF00D, 6, 1'b0, "b2b_rd");
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d acks outstanding, required 0", expq.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    test_reset();
    test_word_wr_rd();
    test_b_reads();
    test_wrap();
    test_simultaneous();
    test_reset_mid_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
